serial_alu_ctrl: RTL and testbench
==================================

# serial_alu_ctrl

Bit-serial sequencer that computes one 32-bit MIPS ALU operation over WIDTH clock cycles by driving a single `_1bit_alu` slice, one bit per cycle, LSB first. It owns the carry chain, the operand/result shift registers, the SLT sign fix-up and the start/done handshake. It is the area-minimal ALU option for the mips32 datapath, sitting between the ALU-control decode and the register write-back mux.

## Interface
- `WIDTH`, 32: operand/result width in bits (≥2).
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE or DONE.
- `op` in 3: ALU op, 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal.
- `a` in WIDTH: operand A, latched on accepted start.
- `b` in WIDTH: operand B, latched on accepted start.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse, result/flags valid.
- `result` out WIDTH: registered result, held until next accepted start.
- `zero` out 1: result == 0, registered with result.
- `overflow` out 1: signed overflow, ADD/SUB only, else 0.
- `c_out` out 1: carry out of MSB slice (0 for AND/OR/illegal).
- `err` out 1: illegal op flag, registered with result.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding 2 bits, IDLE = 0.
- IDLE/DONE + start + legal op: latch a, b, op into shift regs; bit counter ← 0; carry ← op[2] (1 for SUB/SLT); → RUN.
- IDLE/DONE + start + illegal op: no RUN; result ← 0, zero ← 1, err ← 1, overflow/c_out ← 0; → DONE.
- RUN, each cycle: slice gets a_q[0], b_q[0], c_in = carry, op = op_q, less = 0; slice handles B inversion for op[2]=1. Slice out shifts into result_q MSB, a_q/b_q shift right, carry ← slice c_out, counter +1.
- Counter at WIDTH−1 (last bit): overflow = carry_in_msb ^ slice c_out; set = slice out ^ overflow. For SLT, result ← {WIDTH−1 zeros, set}, overflow reported 0. c_out, zero, err ← 0 registered same edge; → DONE.
- DONE: done = 1 for exactly one cycle; no start → IDLE.
- start during RUN ignored, not queued. Operand changes after acceptance have no effect.
- Reset: state IDLE; busy, done, result, zero, overflow, c_out, err all 0; counter and shift regs cleared. Reset mid-RUN aborts with no done pulse.

## Timing
- Start sampled at edge E0; RUN during cycles 1..WIDTH; done high in cycle WIDTH+1 (33 for WIDTH=32). Illegal op: done in cycle 1.
- Back-to-back: start in DONE cycle accepted; next done WIDTH+1 cycles later. Throughput 1 op per WIDTH+1 cycles.
- busy high exactly WIDTH cycles per legal op. busy and done never high together.
- All outputs registered; no combinational path from inputs to outputs.
- Counter width $clog2(WIDTH); wrap at WIDTH−1 never reached in IDLE.

## Structure
- `alu_pkg`: op codes (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT), state enum, default WIDTH.
- One sub-module: the existing `_1bit_alu` slice, instantiated once. FSM, counter and shift registers stay in `serial_alu_ctrl`.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, c_out 0, zero 0, done in cycle 33, busy 32 cycles.
- SUB 5 − 5 → result 0, zero 1, c_out 1, overflow 0; SUB 0x80000000 − 1 → 0x7FFFFFFF, overflow 1.
- SLT −1 vs 1 → 1; SLT 1 vs −1 → 0; SLT 0x80000000 vs 1 (overflow path) → 1; overflow output 0 in all three.
- AND/OR 0xF0F0F0F0, 0x0FF00FF0 → AND 0x00F000F0, OR 0xFFF0FFF0, c_out 0.
- start held high through RUN → single op only; start asserted in DONE cycle → second done exactly 33 cycles after first.
- reset at RUN cycle 10 → next cycle busy 0, result 0, no done; op 3'b011 → err 1, result 0, zero 1, done in cycle 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   - ALU op codes as seen on the op input (other codes are illegal)
//   - sequencer state encoding (2 bits, IDLE = 0)
//   - default operand width and a legality helper
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/response bundle of the bit-serial ALU.
//   master: drives start, op, a, b; observes busy, done, result and flags
//   slave : the sequencer side (serial_alu_ctrl)
interface serial_alu_ctrl_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             c_out;
    logic             err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero, overflow, c_out, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero, overflow, c_out, err
    );
endinterface

// File: rtl/_1bit_alu.sv
// One-bit MIPS ALU slice.
//   a, b   : operand bits          c_in : carry in
//   less   : value passed out for op[1:0] = 11 (SLT)
//   op     : op[2] inverts b, op[1:0] selects AND/OR/ADD/LESS
//   out    : selected result bit   sum  : raw adder bit (the "set" source)
//   c_out  : adder carry out
module _1bit_alu (
    input  logic       a,
    input  logic       b,
    input  logic       c_in,
    input  logic       less,
    input  logic [2:0] op,
    output logic       out,
    output logic       sum,
    output logic       c_out
);
    logic b_eff;

    assign b_eff = b ^ op[2];
    assign sum   = a ^ b_eff ^ c_in;
    assign c_out = (a & b_eff) | (c_in & (a ^ b_eff));

    always_comb begin
        case (op[1:0])
            2'b00:   out = a & b_eff;
            2'b01:   out = a | b_eff;
            2'b10:   out = sum;
            default: out = less;
        endcase
    end
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer: computes one ALU op over WIDTH cycles, LSB first,
// through a single _1bit_alu slice. Owns the carry chain, operand/result
// shift registers, SLT sign fix-up and the start/done handshake.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of serial_alu_ctrl_if (start/op/a/b in,
//           busy/done/result/zero/overflow/c_out/err out, all registered)
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    serial_alu_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             zero_q, overflow_q, c_out_q, err_q;

    logic             slice_out, slice_sum, slice_cout;
    logic             last_bit, idle_like, start_legal, start_illegal;
    logic             ovf_raw, set_bit, arith_op;
    logic [WIDTH-1:0] result_shift, result_final;

    _1bit_alu u_slice (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c_in  (carry_q),
        .less  (1'b0),
        .op    (op_q),
        .out   (slice_out),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    assign last_bit      = (cnt_q == CNT_W'(WIDTH - 1));
    assign idle_like     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start_legal   = idle_like && bus.start && op_legal(bus.op);
    assign start_illegal = idle_like && bus.start && !op_legal(bus.op);

    // MSB slice: overflow is carry into MSB xor carry out of MSB; the true
    // sign of (a - b) is the raw sum bit corrected by that overflow.
    assign ovf_raw      = carry_q ^ slice_cout;
    assign set_bit      = slice_sum ^ ovf_raw;
    assign arith_op     = op_q[1];
    assign result_shift = {slice_out, result_q[WIDTH-1:1]};
    assign result_final = (op_q == OP_SLT) ? WIDTH'(set_bit) : result_shift;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_legal)        state_d = ST_RUN;
                else if (start_illegal) state_d = ST_DONE;
                else                    state_d = ST_IDLE;
            end
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            c_out_q    <= 1'b0;
            err_q      <= 1'b0;
        end else if (start_legal) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            cnt_q   <= '0;
            carry_q <= bus.op[2];   // +1 of two's-complement negate for SUB/SLT
        end else if (start_illegal) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            c_out_q    <= 1'b0;
            err_q      <= 1'b1;
        end else if (state_q == ST_RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                result_q   <= result_final;
                zero_q     <= (result_final == '0);
                overflow_q <= arith_op && (op_q != OP_SLT) && ovf_raw;
                c_out_q    <= arith_op && slice_cout;
                err_q      <= 1'b0;
            end else begin
                result_q <= result_shift;
            end
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = overflow_q;
    assign bus.c_out    = c_out_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: directed corner cases plus
// randomized ops, compared against a word-level arithmetic model.
module tb_serial_alu_ctrl;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl_if #(.WIDTH(W)) bus ();

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        co;
        logic        er;
        int          lat;
        int          busy_cycles;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Word-level reference: plain 33-bit arithmetic and signed compare.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        e.ov = 1'b0;
        e.co = 1'b0;
        e.er = 1'b0;
        e.lat = W + 1;
        e.busy_cycles = W;
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[31:0];
                e.co = s[32];
                e.ov = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            3'b110: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.res = s[31:0];
                e.co = s[32];
                e.ov = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            3'b111: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.co = s[32];
                e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end
            default: begin
                e.res = 32'd0;
                e.er = 1'b1;
                e.lat = 1;
                e.busy_cycles = 0;
            end
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Called just after a falling edge; returns just after the falling edge
    // of the done cycle so a following call is a back-to-back request.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input string tag);
        exp_t e;
        int   n = 0;
        int   nbusy = 0;
        bit   seen = 1'b0;
        bit   overlap = 1'b0;
        e = model(op, a, b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.busy) nbusy++;
            if (bus.busy && bus.done) overlap = 1'b1;
            if (bus.done) seen = 1'b1;
            else begin
                bus.start = hold && (n < W);
                bus.a = $urandom;   // post-acceptance operand changes must not matter
                bus.b = $urandom;
            end
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, n, e.lat);
        check({tag, "_busy_cycles"}, nbusy, e.busy_cycles);
        check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        check({tag, "_result"}, bus.result, e.res);
        check({tag, "_zero"}, 32'(bus.zero), 32'(e.z));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(e.ov));
        check({tag, "_c_out"}, 32'(bus.c_out), 32'(e.co));
        check({tag, "_err"}, 32'(bus.err), 32'(e.er));
    endtask

    task automatic check_quiet(input string tag, input logic [31:0] held);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
        check({tag, "_held_result"}, bus.result, held);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          dones;
        logic [2:0]  ops [8] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b010, 3'b110, 3'b111};
        logic [2:0]  bad [3] = '{3'b011, 3'b100, 3'b101};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_flags", {28'd0, bus.zero, bus.overflow, bus.c_out, bus.err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ovf");
        check_quiet("add_ovf", 32'h8000_0000);
        run_op(3'b110, 32'd5, 32'd5, 1'b0, "sub_eq");
        run_op(3'b110, 32'h8000_0000, 32'd1, 1'b0, "sub_ovf");    // back-to-back
        run_op(3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0, "slt_m1_1");
        run_op(3'b111, 32'd1, 32'hFFFF_FFFF, 1'b0, "slt_1_m1");
        run_op(3'b111, 32'h8000_0000, 32'd1, 1'b0, "slt_ovf");
        run_op(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, "and");
        run_op(3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, "or");
        @(negedge clk);
        run_op(3'b010, 32'h1234_5678, 32'h0000_1111, 1'b1, "hold_start");
        check_quiet("hold_start", 32'h1234_6789);

        // Reset during RUN cycle 10: aborts with no done pulse.
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0101_0101;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_abort_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);

        run_op(3'b011, 32'h1111_1111, 32'h2222_2222, 1'b0, "illegal");
        run_op(3'b010, 32'hFFFF_FFFF, 32'd1, 1'b0, "add_after_illegal");

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 9) == 0) ? bad[$urandom_range(0, 2)] : ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            run_op(op, a, b, 1'b0, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
